// File: rtl/spi_reg_peripheral.sv
// SPI peripheral in front of a small register file.
// The controller sends a command word and then data words. The command word
// carries a write flag in its MSB and a start address in its low bits.
// Write data goes into consecutive registers. Read data comes out of
// consecutive registers on miso. The address wraps modulo NUM_REGS.
// All SPI pins are oversampled in the clk domain.
// Ports:
//   clk        system clock; everything is synchronous to its rising edge
//   rst        synchronous active-high reset
//   sck        SPI clock from the controller (asynchronous)
//   ss         active-low chip select (asynchronous)
//   mosi       controller-to-peripheral data, MSB first
//   miso       peripheral-to-controller data, MSB first
//   reg_out    flattened register file, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_strobe  one-clk pulse per completed register write
//   wr_addr    address of the write flagged by wr_strobe
//   frame_err  one-clk pulse when ss deasserts in the middle of a word
module spi_reg_peripheral #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int CPOL       = 0,
   parameter int CPHA       = 0
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     sck,
   input  logic                                     ss,
   input  logic                                     mosi,
   output logic                                     miso,
   output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]    reg_out,
   output logic                                     wr_strobe,
   output logic [ADDR_WIDTH-1:0]                    wr_addr,
   output logic                                     frame_err
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam int CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH-1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   logic [1:0]                     sck_sync_r, ss_sync_r, mosi_sync_r;
   logic                           sck_prev_r, ss_prev_r;
   logic [1:0]                     flush_cnt_r;
   logic                           armed_r;
   state_t                         state_r, state_nxt_s;
   logic [CNT_W-1:0]               bit_cnt_r;
   logic [DATA_WIDTH-2:0]          rx_r;
   logic [DATA_WIDTH-1:0]          tx_r;
   logic                           skip_r;
   logic                           wr_flag_r;
   logic [ADDR_WIDTH-1:0]          addr_r;
   logic [NUM_REGS*DATA_WIDTH-1:0] regs_r;
   logic                           miso_r, wr_strobe_r, frame_err_r;
   logic [ADDR_WIDTH-1:0]          wr_addr_r;

   logic                           sck_s, ss_s, mosi_s;
   logic                           sck_rise_s, sck_fall_s, ss_fall_s, ss_rise_s;
   logic                           sample_edge_s, shift_edge_s, in_frame_s, word_done_s;
   logic [DATA_WIDTH-1:0]          rx_word_s, rd_data_s;
   logic [ADDR_WIDTH-1:0]          cmd_addr_s, addr_inc_s, rd_addr_s;

   assign sck_s  = sck_sync_r[1];
   assign ss_s   = ss_sync_r[1];
   assign mosi_s = mosi_sync_r[1];

   assign sck_rise_s = sck_s & ~sck_prev_r;
   assign sck_fall_s = ~sck_s & sck_prev_r;
   // A falling ss edge counts only after the post-reset synchronizer flush has
   // seen ss high. A frame that was already open when rst hit is ignored.
   assign ss_fall_s  = ~ss_s & ss_prev_r & armed_r;
   assign ss_rise_s  = ss_s & ~ss_prev_r;

   assign sample_edge_s = (CPOL == CPHA) ? sck_rise_s : sck_fall_s;
   assign shift_edge_s  = (CPOL == CPHA) ? sck_fall_s : sck_rise_s;

   assign in_frame_s  = (state_r != ST_IDLE);
   assign word_done_s = in_frame_s & ~ss_rise_s & sample_edge_s & (bit_cnt_r == LAST_BIT);
   assign rx_word_s   = {rx_r, mosi_s};
   assign cmd_addr_s  = rx_word_s[ADDR_WIDTH-1:0];
   assign addr_inc_s  = addr_r + ADDR_WIDTH'(1);
   // On a command word, read from the start address. On a data word, read
   // from the following address.
   assign rd_addr_s   = (state_r == ST_CMD) ? cmd_addr_s : addr_inc_s;
   assign rd_data_s   = regs_r[int'(rd_addr_s)*DATA_WIDTH +: DATA_WIDTH];

   assign miso      = miso_r;
   assign reg_out   = regs_r;
   assign wr_strobe = wr_strobe_r;
   assign wr_addr   = wr_addr_r;
   assign frame_err = frame_err_r;

   // Input synchronizers, edge-detect history and post-reset arming
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_r  <= 2'b00;
         ss_sync_r   <= 2'b11;
         mosi_sync_r <= 2'b00;
         sck_prev_r  <= 1'b0;
         ss_prev_r   <= 1'b1;
         flush_cnt_r <= 2'd0;
         armed_r     <= 1'b0;
      end else begin
         sck_sync_r  <= {sck_sync_r[0], sck};
         ss_sync_r   <= {ss_sync_r[0], ss};
         mosi_sync_r <= {mosi_sync_r[0], mosi};
         sck_prev_r  <= sck_s;
         ss_prev_r   <= ss_s;
         if (flush_cnt_r != 2'd2) begin
            flush_cnt_r <= flush_cnt_r + 2'd1;
         end
         // After two clocks the reset value of ss_sync_r has been flushed out.
         if (flush_cnt_r == 2'd2 && ss_s) begin
            armed_r <= 1'b1;
         end
      end
   end

   // Frame state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: ss framing plus the end of the command word
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ss_fall_s) state_nxt_s = ST_CMD;
            else           state_nxt_s = ST_IDLE;
         end
         ST_CMD: begin
            if (ss_rise_s)        state_nxt_s = ST_IDLE;
            else if (word_done_s) state_nxt_s = ST_DATA;
            else                  state_nxt_s = ST_CMD;
         end
         ST_DATA: begin
            if (ss_rise_s) state_nxt_s = ST_IDLE;
            else           state_nxt_s = ST_DATA;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Bit counting, shift registers, register file and output pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_r   <= '0;
         rx_r        <= '0;
         tx_r        <= '0;
         skip_r      <= 1'b0;
         wr_flag_r   <= 1'b0;
         addr_r      <= '0;
         regs_r      <= '0;
         miso_r      <= 1'b0;
         wr_strobe_r <= 1'b0;
         wr_addr_r   <= '0;
         frame_err_r <= 1'b0;
      end else begin
         wr_strobe_r <= 1'b0;
         frame_err_r <= 1'b0;
         if (ss_rise_s) begin
            // A partial word is dropped: no write and no address change.
            bit_cnt_r <= '0;
            skip_r    <= 1'b0;
            if (in_frame_s && bit_cnt_r != '0) begin
               frame_err_r <= 1'b1;
            end
         end else if (in_frame_s && sample_edge_s) begin
            rx_r <= rx_word_s[DATA_WIDTH-2:0];
            if (bit_cnt_r == LAST_BIT) begin
               bit_cnt_r <= '0;
               if (state_r == ST_CMD) begin
                  wr_flag_r <= rx_word_s[DATA_WIDTH-1];
                  addr_r    <= cmd_addr_s;
                  tx_r      <= rx_word_s[DATA_WIDTH-1] ? '0 : rd_data_s;
                  skip_r    <= 1'b1;
               end else begin
                  if (wr_flag_r) begin
                     regs_r[int'(addr_r)*DATA_WIDTH +: DATA_WIDTH] <= rx_word_s;
                     wr_strobe_r <= 1'b1;
                     wr_addr_r   <= addr_r;
                  end else begin
                     tx_r   <= rd_data_s;
                     skip_r <= 1'b1;
                  end
                  addr_r <= addr_inc_s;
               end
            end else begin
               bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
         end else if (state_r == ST_DATA && shift_edge_s) begin
            // The first shift edge after a load keeps the freshly loaded MSB
            // on the line. Every later shift edge moves the next bit out.
            if (skip_r) begin
               skip_r <= 1'b0;
            end else begin
               tx_r <= {tx_r[DATA_WIDTH-2:0], 1'b0};
            end
         end
         miso_r <= (state_r == ST_DATA && !wr_flag_r) ? tx_r[DATA_WIDTH-1] : 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
module tb_spi_reg_peripheral;

   localparam int H = 8;   // sck half period in clk cycles

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic sck_b, ss_b, mosi_b, mode3;
   logic sck0, ss0, sck3, ss3;
   logic miso0, miso3, wr_strobe0, wr_strobe3, frame_err0, frame_err3;
   logic [31:0] reg_out0, reg_out3;
   logic [1:0]  wr_addr0, wr_addr3;
   logic        miso_sel;

   // Only the selected DUT sees bus activity; the other sits idle.
   assign sck0     = mode3 ? 1'b0 : sck_b;
   assign ss0      = mode3 ? 1'b1 : ss_b;
   assign sck3     = mode3 ? sck_b : 1'b1;
   assign ss3      = mode3 ? ss_b : 1'b1;
   assign miso_sel = mode3 ? miso3 : miso0;

   spi_reg_peripheral #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CPOL(0), .CPHA(0)) dut0 (
      .clk(clk), .rst(rst), .sck(sck0), .ss(ss0), .mosi(mosi_b), .miso(miso0),
      .reg_out(reg_out0), .wr_strobe(wr_strobe0), .wr_addr(wr_addr0), .frame_err(frame_err0));

   spi_reg_peripheral #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CPOL(1), .CPHA(1)) dut3 (
      .clk(clk), .rst(rst), .sck(sck3), .ss(ss3), .mosi(mosi_b), .miso(miso3),
      .reg_out(reg_out3), .wr_strobe(wr_strobe3), .wr_addr(wr_addr3), .frame_err(frame_err3));

   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_wr_q[$];
   bit         exp_fe_q[$];
   logic [7:0] exp_rd_q[$];
   logic [7:0] got_rd_q[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected entries whenever a DUT presents a response
   wr_t         mon_w;
   logic [31:0] mon_r;
   logic [1:0]  mon_a;
   logic [7:0]  mon_e, mon_g;
   always @(negedge clk) begin
      if (wr_strobe0 || wr_strobe3) begin
         mon_a = mode3 ? wr_addr3 : wr_addr0;
         mon_r = mode3 ? reg_out3 : reg_out0;
         if (exp_wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected: got strobe at addr %0d, expected none", mon_a);
         end else begin
            mon_w = exp_wr_q.pop_front();
            chk("wr_dut", {30'd0, wr_strobe3, wr_strobe0}, mode3 ? 32'd2 : 32'd1);
            chk("wr_addr", {30'd0, mon_a}, {30'd0, mon_w.addr});
            chk("wr_data", (mon_r >> (int'(mon_w.addr) * 8)) & 32'hFF, {24'd0, mon_w.data});
         end
      end
      if (frame_err0 || frame_err3) begin
         if (exp_fe_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_err_unexpected: got pulse, expected none");
         end else begin
            void'(exp_fe_q.pop_front());
            chk("frame_err_dut", {30'd0, frame_err3, frame_err0}, mode3 ? 32'd2 : 32'd1);
         end
      end
      if (got_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
         mon_g = got_rd_q.pop_front();
         mon_e = exp_rd_q.pop_front();
         chk("miso_word", {24'd0, mon_g}, {24'd0, mon_e});
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shift nbits of tx out MSB first, capturing miso at each sample edge
   task automatic xfer_bits(input logic [7:0] tx, input int nbits, input bit rec,
                            input logic [7:0] exp_miso);
      logic [7:0] rx;
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!mode3) begin
            mosi_b = tx[7-i];
            wait_clk(H);
            rx = {rx[6:0], miso_sel};
            sck_b = 1'b1;
            wait_clk(H);
            sck_b = 1'b0;
         end else begin
            sck_b = 1'b0;
            mosi_b = tx[7-i];
            wait_clk(H);
            rx = {rx[6:0], miso_sel};
            sck_b = 1'b1;
            wait_clk(H);
         end
      end
      if (rec) begin
         exp_rd_q.push_back(exp_miso);
         got_rd_q.push_back(rx);
      end
   endtask

   task automatic word(input logic [7:0] tx, input logic [7:0] exp_miso);
      xfer_bits(tx, 8, 1'b1, exp_miso);
   endtask

   task automatic ss_on();
      ss_b = 1'b0;
      wait_clk(H);
   endtask

   task automatic ss_off();
      wait_clk(H);
      ss_b = 1'b1;
      wait_clk(2 * H);
   endtask

   function automatic wr_t mk(input logic [1:0] a, input logic [7:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sck_b = 1'b0; ss_b = 1'b1; mosi_b = 1'b0; mode3 = 1'b0;
      wait_clk(4);
      rst = 1'b0;
      wait_clk(4);
      chk("rst_reg_out0", reg_out0, 32'h0);
      chk("rst_miso0", {31'd0, miso0}, 32'd0);
      chk("rst_wr_strobe0", {31'd0, wr_strobe0}, 32'd0);
      chk("rst_frame_err0", {31'd0, frame_err0}, 32'd0);
      chk("rst_reg_out3", reg_out3, 32'h0);
      chk("rst_miso3", {31'd0, miso3}, 32'd0);

      // single write to reg1
      exp_wr_q.push_back(mk(2'd1, 8'hA5));
      ss_on(); word(8'h81, 8'h00); word(8'hA5, 8'h00); ss_off();
      chk("single_write", reg_out0, 32'h0000A500);

      // burst with wrap 3 -> 0
      exp_wr_q.push_back(mk(2'd3, 8'h11));
      exp_wr_q.push_back(mk(2'd0, 8'h22));
      ss_on(); word(8'h83, 8'h00); word(8'h11, 8'h00); word(8'h22, 8'h00); ss_off();
      chk("burst_wrap", reg_out0, 32'h1100A522);

      // read from reg1: A5 then reg2 = 00
      ss_on(); word(8'h01, 8'h00); word(8'h00, 8'hA5); word(8'hFF, 8'h00); ss_off();
      chk("read_no_modify", reg_out0, 32'h1100A522);

      // partial data word then ss high
      exp_fe_q.push_back(1'b1);
      ss_on(); word(8'h82, 8'h00); xfer_bits(8'hFF, 5, 1'b0, 8'h00); ss_off();
      chk("abort_reg2", reg_out0, 32'h1100A522);
      exp_wr_q.push_back(mk(2'd2, 8'h5A));
      ss_on(); word(8'h82, 8'h00); word(8'h5A, 8'h00); ss_off();
      chk("after_abort", reg_out0, 32'h115AA522);

      // ss falls together with an sck rising edge: that edge is not counted
      exp_wr_q.push_back(mk(2'd0, 8'h77));
      ss_b = 1'b0; sck_b = 1'b1;
      wait_clk(H);
      sck_b = 1'b0;
      wait_clk(H);
      word(8'h80, 8'h00); word(8'h77, 8'h00); ss_off();
      chk("ss_sck_same_cycle", reg_out0, 32'h115AA577);

      // read all four registers starting at 0
      ss_on();
      word(8'h00, 8'h00); word(8'h00, 8'h77); word(8'h00, 8'hA5);
      word(8'h00, 8'h5A); word(8'h00, 8'h11);
      ss_off();
      chk("read_all_no_modify", reg_out0, 32'h115AA577);

      // mode 3 instance
      sck_b = 1'b1;
      wait_clk(2);
      mode3 = 1'b1;
      wait_clk(4);
      exp_wr_q.push_back(mk(2'd0, 8'h3C));
      ss_on(); word(8'h80, 8'h00); word(8'h3C, 8'h00); ss_off();
      chk("m3_write", reg_out3, 32'h0000003C);
      ss_on(); word(8'h00, 8'h00); word(8'h00, 8'h3C); ss_off();

      // rst in the middle of a data word: no write, no frame_err, regs cleared
      ss_on(); word(8'h81, 8'h00); xfer_bits(8'hF0, 4, 1'b0, 8'h00);
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      xfer_bits(8'hF0, 4, 1'b0, 8'h00);
      ss_off();
      chk("m3_rst_regs3", reg_out3, 32'h0);
      chk("m3_rst_regs0", reg_out0, 32'h0);
      chk("m3_rst_miso3", {31'd0, miso3}, 32'd0);

      // block works again after the next ss falling edge
      exp_wr_q.push_back(mk(2'd2, 8'h99));
      ss_on(); word(8'h82, 8'h00); word(8'h99, 8'h00); ss_off();
      chk("m3_rearm", reg_out3, 32'h00990000);

      wait_clk(20);
      chk("wr_drained", exp_wr_q.size(), 32'd0);
      chk("fe_drained", exp_fe_q.size(), 32'd0);
      chk("rd_drained", exp_rd_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
